// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter with registered Gray/binary outputs and a wrap pulse.
// Optional self-check against an external binary reference, enabled by GRAY_COUNTER_CHECK_EN.
module gray_counter_param #(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] ref_bin,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap,
    output logic             chk_err
);

    if (DEPTH_LOG2 == 0 || DEPTH_LOG2 > WIDTH) begin : g_bad_depth
        $error("gray_counter_param: DEPTH_LOG2=%0d outside 1..WIDTH=%0d", DEPTH_LOG2, WIDTH);
    end

    localparam logic [DEPTH_LOG2-1:0] CNT_MAX = '1;

    logic [DEPTH_LOG2-1:0] bin_q;
    logic [DEPTH_LOG2-1:0] bin_d;
    logic [DEPTH_LOG2-1:0] gray_q;
    logic [DEPTH_LOG2-1:0] gray_d;
    logic                  wrap_q;
    logic                  wrap_d;

    // Next count: clr > load > enable; Gray is derived from the next binary and registered.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (clr) begin
            bin_d = '0;
        end else if (load) begin
            bin_d = load_val[DEPTH_LOG2-1:0];
        end else if (enable) begin
            if (up_dn) begin
                bin_d  = bin_q + DEPTH_LOG2'(1);
                wrap_d = (bin_q == CNT_MAX);
            end else begin
                bin_d  = bin_q - DEPTH_LOG2'(1);
                wrap_d = (bin_q == '0);
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = WIDTH'(bin_q);
    assign gray_out = WIDTH'(gray_q);
    assign wrap     = wrap_q;

`ifdef GRAY_COUNTER_CHECK_EN
    logic                  chk_skip_q;
    logic                  chk_err_q;
    logic                  chk_err_d;
    logic                  mismatch_c;
    logic [DEPTH_LOG2-1:0] ref_low_c;
    logic [DEPTH_LOG2-1:0] ref_gray_c;
    logic                  unused_load_val;

    assign unused_load_val = ^load_val;

    // Skip the edge right after reset release, clr or load: the reference may still lag.
    always_comb begin
        ref_low_c  = ref_bin[DEPTH_LOG2-1:0];
        ref_gray_c = ref_low_c ^ (ref_low_c >> 1);
        mismatch_c = !chk_skip_q &&
                     ((gray_q != ref_gray_c) || ((ref_bin >> DEPTH_LOG2) != '0));
        chk_err_d  = clr ? 1'b0 : (chk_err_q | mismatch_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_skip_q <= 1'b1;
            chk_err_q  <= 1'b0;
        end else begin
            chk_skip_q <= clr | load;
            chk_err_q  <= chk_err_d;
            if (mismatch_c)
                $error("gray self-check at %0t: gray_out=%0h ref_bin=%0h (ref gray %0h)",
                       $time, gray_q, ref_bin, ref_gray_c);
        end
    end

    assign chk_err = chk_err_q;
`else
    logic unused_inputs;

    assign unused_inputs = ^{load_val, ref_bin};
    assign chk_err       = 1'b0;
`endif

endmodule
